// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC unit and its branch target buffer.
// Provides the default datapath width, the instruction size, the 2-bit
// direction-counter encodings and the saturating counter step functions.
package pc_pkg;

   localparam int unsigned XLEN_DEF   = 32;
   localparam int unsigned INST_BYTES = 4;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_t;

   // Step toward strong-taken, saturating at CTR_ST
   function automatic ctr_t ctr_inc(input ctr_t c);
      ctr_t r;
      case (c)
         CTR_SNT: r = CTR_WNT;
         CTR_WNT: r = CTR_WT;
         default: r = CTR_ST;
      endcase
      return r;
   endfunction

   // Step toward strong-not-taken, saturating at CTR_SNT
   function automatic ctr_t ctr_dec(input ctr_t c);
      ctr_t r;
      case (c)
         CTR_ST:  r = CTR_WT;
         CTR_WT:  r = CTR_WNT;
         default: r = CTR_SNT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pc_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (clears valid/ctr)
//   lookup_pc                address looked up combinationally
//   pred_taken_c             lookup hit with counter in a taken state
//   pred_target_c            stored target on a taken prediction, else 0
//   upd_valid/pc/taken/target  branch resolution written at the clock edge
module btb
   import pc_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            pred_taken_c,
   output logic [XLEN-1:0] pred_target_c,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target
);

   localparam int unsigned IDX   = $clog2(DEPTH);
   localparam int unsigned TAG_W = XLEN - IDX - 2;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [TAG_W-1:0] tag_d    [DEPTH];
   logic [XLEN-1:0]  target_q [DEPTH];
   logic [XLEN-1:0]  target_d [DEPTH];
   ctr_t             ctr_q    [DEPTH];
   ctr_t             ctr_d    [DEPTH];

   logic [IDX-1:0]   lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             lk_hit, up_hit;

   // Byte-offset bits never take part in indexing or tagging
   logic unused_offset_bits;
   assign unused_offset_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

   // Combinational read port
   always_comb begin
      lk_idx        = lookup_pc[IDX+1:2];
      lk_tag        = lookup_pc[XLEN-1:IDX+2];
      lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken_c  = lk_hit && ctr_q[lk_idx][1];
      pred_target_c = pred_taken_c ? target_q[lk_idx] : '0;
   end

   // Next table contents from the resolution port
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      up_idx   = upd_pc[IDX+1:2];
      up_tag   = upd_pc[XLEN-1:IDX+2];
      up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      if (upd_valid) begin
         if (up_hit) begin
            ctr_d[up_idx] = upd_taken ? ctr_inc(ctr_q[up_idx]) : ctr_dec(ctr_q[up_idx]);
            if (upd_taken) target_d[up_idx] = upd_target;
         end else if (upd_taken) begin
            // Allocate, evicting whatever aliased into this slot
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = upd_target;
            ctr_d[up_idx]    = CTR_WT;
         end
      end
   end

   // Control state: cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         ctr_q   <= '{default: CTR_SNT};
      end else begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
      end
   end

   // Payload state: meaningless while the valid bit is clear, so not reset
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter with BTB-driven next-fetch prediction.
// Next-PC priority: rst > redirect > stall > BTB predict > pc+4.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           hold pc (overridden by redirect)
//   redirect/redirect_pc   load corrected fetch address
//   upd_*           branch resolution from EX, trains the BTB
//   pc              registered fetch address
//   pred_taken/pred_target  BTB prediction for the current pc (combinational)
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN       = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter bit              TRACE_MODE = 1'b0,
   parameter int unsigned     BTB_DEPTH  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   output logic [XLEN-1:0] pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target
);

   // Trace mode starts one instruction early so the first step lands on RESET_PC
   localparam logic [XLEN-1:0] RST_VAL =
      TRACE_MODE ? (RESET_PC - XLEN'(INST_BYTES)) : RESET_PC;

   logic [XLEN-1:0] pc_q, pc_d;

   btb #(
      .XLEN  (XLEN),
      .DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk           (clk),
      .rst           (rst),
      .lookup_pc     (pc_q),
      .pred_taken_c  (pred_taken),
      .pred_target_c (pred_target),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_taken     (upd_taken),
      .upd_target    (upd_target)
   );

   // Next-PC mux; pc+4 wraps modulo 2^XLEN
   always_comb begin
      pc_d = pc_q + XLEN'(INST_BYTES);
      if (redirect)        pc_d = redirect_pc;
      else if (stall)      pc_d = pc_q;
      else if (pred_taken) pc_d = pred_target;
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RST_VAL;
      else     pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule
